// File: rtl/s4ga_cfg_streamer_if.sv
// s4ga configuration streamer load port.
// Valid/ready segment bus from the frame source.
interface s4ga_cfg_streamer_if #(
  parameter int SI_W = 4
);
  logic            ld_valid;
  logic            ld_ready;
  logic [SI_W-1:0] ld_data;
  logic            ld_last;

  modport master (
    output ld_valid,
    output ld_data,
    output ld_last,
    input  ld_ready
  );

  modport slave (
    input  ld_valid,
    input  ld_data,
    input  ld_last,
    output ld_ready
  );
endinterface

// File: rtl/s4ga_cfg_streamer.sv
// s4ga configuration streamer: loads one LUT frame,
// resets the core, then replays the frame forever.
module s4ga_cfg_streamer #(
  parameter int N    = 241,
  parameter int K    = 5,
  parameter int I    = 2,
  parameter int SI_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  s4ga_cfg_streamer_if.slave  ld,
  input  logic                reload,
  output logic                core_rst,
  output logic [SI_W-1:0]     core_si,
  output logic                frame_start,
  output logic                loaded,
  output logic                err
);

  localparam int IDX_W     = $clog2(3 + I + N);
  localparam int IDX_SEGS  = (IDX_W + SI_W - 1) / SI_W;
  localparam int MASK_SEGS = (2 ** K + SI_W - 1) / SI_W;
  localparam int LL        = K * IDX_SEGS + MASK_SEGS;
  localparam int FRAME     = N * LL;
  localparam int A_W       = $clog2(FRAME);
  localparam int RST_CYC   = N + 2;
  localparam int C_W       = $clog2(RST_CYC + 1);

  localparam logic [A_W-1:0] A_LAST = A_W'(FRAME - 1);
  localparam logic [C_W-1:0] C_LAST = C_W'(RST_CYC - 1);

  typedef enum logic [1:0] {
    S_LOAD,
    S_CRST,
    S_RUN
  } state_t;

  state_t          state;
  state_t          nxt;
  logic [A_W-1:0]  wa;
  logic [A_W-1:0]  ra;
  logic [C_W-1:0]  cnt;
  logic [SI_W-1:0] mem [FRAME];
  logic            hs;
  logic            at_end;
  logic            rd_en;

  // A handshake racing a reload is dropped with the partial frame.
  assign hs = ld.ld_valid && ld.ld_ready
           && (state == S_LOAD) && !reload;
  assign at_end = (wa == A_LAST);
  // Read for cycle k is issued one edge early, so RUN starts gapless.
  assign rd_en = (nxt == S_RUN);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= S_LOAD;
    else      state <= nxt;
  end

  // Next-state decode; reload wins from any state.
  always_comb begin
    nxt = state;
    unique case (1'b1)
      reload:
        nxt = S_LOAD;
      !reload && state == S_LOAD:
        nxt = (hs && ld.ld_last && at_end) ? S_CRST : S_LOAD;
      !reload && state == S_CRST:
        nxt = (cnt == C_LAST) ? S_RUN : S_CRST;
      !reload && state == S_RUN:
        nxt = S_RUN;
      default:
        nxt = S_LOAD;
    endcase
  end

  // Control registers: write pointer, reset timer, read pointer, flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wa          <= '0;
      ra          <= '0;
      cnt         <= '0;
      err         <= 1'b0;
      ld.ld_ready <= 1'b0;
      core_rst    <= 1'b1;
      loaded      <= 1'b0;
    end else begin
      ld.ld_ready <= (nxt == S_LOAD);
      core_rst    <= (nxt != S_RUN);
      loaded      <= (nxt == S_RUN);
      cnt         <= (state == S_CRST) ? cnt + C_W'(1) : '0;
      if (reload) begin
        wa <= '0;
      end else if (hs) begin
        if (ld.ld_last) begin
          wa  <= '0;
          err <= !at_end;
        end else if (at_end) begin
          wa  <= '0;
          err <= 1'b1;
        end else begin
          wa <= wa + A_W'(1);
        end
      end
      if (rd_en) ra <= at_ra_end(ra) ? '0 : ra + A_W'(1);
      else       ra <= '0;
    end
  end

  function automatic logic at_ra_end(input logic [A_W-1:0] a);
    return a == A_LAST;
  endfunction

  // Segment RAM write port.
  always_ff @(posedge clk) begin
    if (hs) mem[wa] <= ld.ld_data;
  end

  // Synchronous read doubles as the registered stream output.
  always_ff @(posedge clk) begin
    if (!rst) begin
      core_si     <= '0;
      frame_start <= 1'b0;
    end else begin
      core_si     <= rd_en ? mem[ra] : '0;
      frame_start <= rd_en && (ra == '0);
    end
  end

endmodule

// File: tb/tb_s4ga_cfg_streamer.sv
// Bench for s4ga_cfg_streamer: reduced config with model
// scoreboard, plus a default-size streaming smoke run.
module tb_s4ga_cfg_streamer;

  localparam int AF   = 9;
  localparam int ARST = 5;
  localparam int BF   = 4338;
  localparam int BRST = 243;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst, a_reload, a_crst, a_fs, a_ld, a_err;
  logic [3:0] a_si;
  logic       b_rst, b_reload, b_crst, b_fs, b_ld, b_err;
  logic [3:0] b_si;

  s4ga_cfg_streamer_if #(.SI_W(4)) a_if ();
  s4ga_cfg_streamer_if #(.SI_W(4)) b_if ();

  s4ga_cfg_streamer #(.N(3), .K(2), .I(1), .SI_W(4)) dut_a (
    .clk(clk), .rst(a_rst), .ld(a_if.slave), .reload(a_reload),
    .core_rst(a_crst), .core_si(a_si), .frame_start(a_fs),
    .loaded(a_ld), .err(a_err)
  );

  s4ga_cfg_streamer dut_b (
    .clk(clk), .rst(b_rst), .ld(b_if.slave), .reload(b_reload),
    .core_rst(b_crst), .core_si(b_si), .frame_start(b_fs),
    .loaded(b_ld), .err(b_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic       crst;
    logic [3:0] si;
    logic       fs;
    logic       ld;
    logic       err;
    logic       rdy;
  } obs_t;

  obs_t exp_q[$];
  obs_t mon_e, mon_a;

  // Behavioural model: phase 0 collecting, 1 holding core reset, 2 replay.
  int         m_mode = 0;
  int         m_cnt = 0;
  int         m_left = 0;
  int         m_k = 0;
  logic       m_err = 1'b0;
  logic       m_rdy = 1'b0;
  logic [3:0] m_buf[AF];
  logic [3:0] m_gold[AF];

  task automatic model_edge(input logic v, input logic [3:0] d,
                            input logic l, input logic rl,
                            input logic r);
    obs_t o;
    if (!r) begin
      m_mode = 0; m_cnt = 0; m_err = 1'b0; m_rdy = 1'b0;
    end else if (rl) begin
      m_mode = 0; m_cnt = 0; m_rdy = 1'b1;
    end else if (m_mode == 0) begin
      if (v && m_rdy) begin
        m_buf[m_cnt] = d;
        if (l) begin
          if (m_cnt == AF - 1) begin
            m_gold = m_buf; m_mode = 1; m_left = ARST; m_err = 1'b0;
          end else begin
            m_err = 1'b1;
          end
          m_cnt = 0;
        end else if (m_cnt == AF - 1) begin
          m_err = 1'b1; m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end
      m_rdy = (m_mode == 0);
    end else if (m_mode == 1) begin
      m_left--;
      if (m_left == 0) begin
        m_mode = 2; m_k = 0;
      end
    end else begin
      m_k++;
    end
    o.crst = (m_mode != 2);
    o.si   = (m_mode == 2) ? m_gold[m_k % AF] : 4'h0;
    o.fs   = (m_mode == 2) && (m_k % AF == 0);
    o.ld   = (m_mode == 2);
    o.err  = m_err;
    o.rdy  = (m_mode == 0) && m_rdy;
    exp_q.push_back(o);
  endtask

  task automatic step_a(input logic v, input logic [3:0] d,
                        input logic l, input logic rl,
                        input logic r);
    @(negedge clk);
    a_if.ld_valid = v;
    a_if.ld_data  = d;
    a_if.ld_last  = l;
    a_reload      = rl;
    a_rst         = r;
    model_edge(v, d, l, rl, r);
  endtask

  task automatic idle_a(input int n, input bit noise);
    for (int i = 0; i < n; i++)
      step_a(noise ? 1'($urandom) : 1'b0, 4'($urandom),
             noise ? 1'($urandom) : 1'b0, 1'b0, 1'b1);
  endtask

  logic tog = 1'b0;

  // gap: 0 continuous, 1 every other cycle, 2 random.
  task automatic send_a(input int n, input int last_at,
                        input int gap, input int base);
    for (int i = 0; i < n; i++) begin
      logic [3:0] d;
      logic       v;
      logic       acc;
      int         g;
      d = (base != 0) ? 4'(base + i) : 4'($urandom);
      acc = 1'b0;
      g = 0;
      while (!acc && g < 50) begin
        if (gap == 0)      v = 1'b1;
        else if (gap == 1) begin tog = ~tog; v = tog; end
        else               v = 1'($urandom);
        acc = v && (m_mode == 0) && m_rdy;
        step_a(v, v ? d : 4'($urandom), (i + 1 == last_at),
               1'b0, 1'b1);
        g++;
      end
      if (!acc) begin
        checks++; errors++;
        $display("FAIL send_timeout seg %0d not accepted", i);
      end
    end
  endtask

  // Scoreboard monitor for the reduced instance.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = {a_crst, a_si, a_fs, a_ld, a_err, a_if.ld_ready};
      chk("a_obs", 32'(mon_a), 32'(mon_e));
    end
  end

  logic [3:0] b_gold[BF];
  bit         b_mon = 1'b0;
  int         bk = 0;
  int         b_fs_cnt = 0;

  // Stream checker for the default-size instance.
  always @(posedge clk) begin
    #1;
    if (b_mon && b_ld) begin
      chk("b_si", 32'(b_si), 32'(b_gold[bk]));
      chk("b_fs", 32'(b_fs), 32'(bk == 0));
      chk("b_run", 32'({b_crst, b_if.ld_ready}), 32'd0);
      if (b_fs) b_fs_cnt++;
      bk = (bk + 1) % BF;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    a_rst = 1'b0; a_reload = 1'b0;
    a_if.ld_valid = 1'b0; a_if.ld_data = 4'h0; a_if.ld_last = 1'b0;
    b_rst = 1'b0; b_reload = 1'b0;
    b_if.ld_valid = 1'b0; b_if.ld_data = 4'h0; b_if.ld_last = 1'b0;

    step_a(0, 0, 0, 0, 0);
    step_a(0, 0, 0, 0, 0);
    idle_a(2, 0);
    send_a(9, 9, 0, 1);
    idle_a(25, 1);

    step_a(0, 0, 0, 1, 1);
    send_a(9, 9, 1, 10);
    idle_a(25, 1);

    step_a(0, 0, 0, 1, 1);
    send_a(7, 7, 2, 0);
    idle_a(2, 0);
    send_a(9, 9, 2, 0);
    idle_a(20, 1);

    step_a(0, 0, 0, 1, 1);
    send_a(10, 0, 0, 0);
    send_a(8, 8, 0, 0);
    idle_a(20, 1);

    step_a(0, 0, 0, 0, 0);
    idle_a(3, 0);
    send_a(9, 9, 2, 0);
    idle_a(12, 1);

    step_a(0, 0, 0, 1, 1);
    send_a(4, 0, 0, 0);
    step_a(1, 4'h5, 0, 1, 1);
    send_a(9, 9, 0, 0);
    idle_a(2, 1);
    step_a(0, 0, 0, 1, 1);
    send_a(9, 9, 2, 0);
    idle_a(30, 1);

    for (int i = 0; i < 80; i++)
      step_a(1'($urandom), 4'($urandom),
             $urandom_range(0, 7) == 0,
             $urandom_range(0, 31) == 0,
             $urandom_range(0, 63) != 0);
    step_a(0, 0, 0, 1, 1);
    send_a(9, 9, 0, 0);
    idle_a(15, 1);
    @(posedge clk);
    #3;
    chk("a_drain", 32'(exp_q.size()), 32'd0);

    b_mon = 1'b1;
    @(negedge clk);
    b_rst = 1'b1;
    for (int i = 0; i < BF; i++) begin
      int   g;
      logic acc;
      b_gold[i] = 4'($urandom);
      g = 0;
      acc = 1'b0;
      while (!acc && g < 8) begin
        @(negedge clk);
        b_if.ld_valid = 1'b1;
        b_if.ld_data  = b_gold[i];
        b_if.ld_last  = (i == BF - 1);
        acc = b_if.ld_ready;
        g++;
      end
      if (!acc) begin
        checks++; errors++;
        $display("FAIL b_load seg %0d not accepted", i);
        break;
      end
    end
    @(negedge clk);
    b_if.ld_valid = 1'b0;
    b_if.ld_last  = 1'b0;
    chk("b_err", 32'(b_err), 32'd0);
    n = 0;
    while (b_crst && n < 1000) begin
      n++;
      @(negedge clk);
    end
    chk("b_rst_cycles", 32'(n), 32'(BRST));
    repeat (2 * BF + 20) @(negedge clk);
    chk("b_fs_count", 32'(b_fs_cnt), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
